register_bank: RTL
==================

# register_bank

Eight-entry, 16-bit general-purpose register bank with one write-back port and a busy scoreboard for multi-cycle results. Sits directly upstream of the 8:1 register read multiplexers in the CPU datapath and drives their eight 16-bit inputs from `reg0`–`reg7`. It also tracks which registers await an outstanding result and raises `stall` when the decode stage reads one of them.

## Interface
Parameters:
- `WIDTH`, 16, data width of each register.
- `NREG`, 8, number of registers; fixed at 8, with a 3-bit address.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `wr_en`  input  1  write-back strobe.
- `wr_addr`  input  3  write-back destination register.
- `wr_data`  input  16  write-back value.
- `issue_en`  input  1  request to mark `issue_dest` busy for a multi-cycle op.
- `issue_dest`  input  3  register that will receive the pending result.
- `issue_ready`  output  1  high when `issue_dest` is not busy, so the issue can be accepted.
- `rd_a_en`, `rd_b_en`  input  1 each  decode stage is reading operand A or B.
- `rd_a_sel`, `rd_b_sel`  input  3 each  operand register numbers; these are the same values presented to the read muxes.
- `reg0` … `reg7`  output  16 each  current register contents, registered and connected straight to the mux inputs.
- `busy`  output  8  scoreboard; bit i means register i has a result pending.
- `pending_cnt`  output  4  population count of `busy` (0–8).
- `stall`  output  1  operand hazard; decode must hold.

## Operation
- On write (`wr_en`=1), register `wr_addr` takes `wr_data` at the clock edge.
  - All eight registers are writable; there is no hardwired zero.
  - The write clears `busy[wr_addr]` at the same edge.
- Issue is accepted when `issue_en & issue_ready`. An accepted issue sets `busy[issue_dest]` at the edge.
- An issue with `issue_ready`=0 is ignored, with no state change. Upstream must hold the request until it is accepted.
- `issue_ready` is `!busy[issue_dest]`, combinational.
- `stall` is `(rd_a_en & busy[rd_a_sel]) | (rd_b_en & busy[rd_b_sel])`, combinational.
  - There is no bypass.
  - A register being written this cycle still stalls a reader this cycle.
  - The new value and the cleared busy bit both become visible after the edge.
- `pending_cnt` is a combinational popcount of `busy`.
- Simultaneous events:
  - Write to register X and accepted issue to X in the same cycle: the data is written and `busy[X]` ends up 1 (issue wins).
  - This can only occur when X was not busy, i.e. a single-cycle ALU write-back racing a new multi-cycle issue.
  - Write and issue to different registers: both take effect independently.
  - Write to a non-busy register: data is written and busy stays 0. This is the normal single-cycle ALU path.
- Reset (asynchronous, any time): all registers go to 0x0000, `busy` goes to 0 and `pending_cnt` to 0.
  - With `busy`=0, `stall` is 0 while its read enables are low, and `issue_ready` is 1.
  - Reset aborts any pending results. A write arriving after reset deasserts is accepted normally.

## Timing
- Write latency is 1 cycle: data presented at edge N appears on `regX` after edge N.
- Issue-to-busy latency is 1 cycle: `stall` can assert for a reader of that register from cycle N+1.
- Write-back-to-unstall is 1 cycle: `stall` drops in the cycle after the write edge.
- `stall`, `issue_ready` and `pending_cnt` are purely combinational from `busy` and the select inputs, with no registered delay.
- Reset values:
  - `reg0`–`reg7` = 0x0000.
  - `busy` = 8'h00 and `pending_cnt` = 0.
  - `issue_ready` = 1.
  - `stall` = 0.

## Structure
- Shared CPU package holds:
  - `WIDTH` = 16, `NREG` = 8, `RADDR_W` = 3.
  - The register-number type (3-bit).
  - The 16-bit data word type.
- One natural sub-module, `reg16_en`: a 16-bit register with load enable and asynchronous active-low clear. It is instantiated eight times, with its enable decoded from `wr_en` and `wr_addr`.
- The busy scoreboard, popcount and hazard logic stay in `register_bank`.

## Test plan
- Reset then write: assert `rst_n`=0, release, write 0x1234 to R3.
  - Expect all `reg*` = 0 during reset.
  - Expect `reg3` = 0x1234 one cycle after the write, with the other registers still 0.
- Issue/stall/write-back: issue to R5, then read R5 on port A.
  - Expect `busy` = 8'h20, `pending_cnt` = 1, `stall` = 1.
  - Write 0xBEEF to R5: `stall` stays 1 that cycle, then the next cycle gives `reg5` = 0xBEEF, `busy` = 0, `stall` = 0.
- Blocked issue: R2 busy, issue to R2 again.
  - Expect `issue_ready` = 0, `busy` unchanged and `pending_cnt` still 1.
- Same-cycle race: R6 idle; write 0x00FF to R6 and issue to R6 in the same cycle.
  - Expect `reg6` = 0x00FF and `busy[6]` = 1.
- Fill and mid-operation reset: issue to all eight registers, giving `pending_cnt` = 8 and `busy` = 8'hFF.
  - Assert `rst_n` asynchronously mid-cycle: `busy` = 0, `pending_cnt` = 0 and `reg*` = 0 immediately, without waiting for a clock edge.
- Port B only: `rd_b_en`=1 on busy R1 and `rd_a_en`=0 on busy R4.
  - Expect `stall` = 1 from port B alone.
  - Drop `rd_b_en`: expect `stall` = 0 even though R4 is still busy.

Source files
------------

// File: rtl/register_bank_pkg.sv
// Shared CPU datapath definitions: register-file geometry, operand types and
// a small popcount helper for the busy scoreboard.
package register_bank_pkg;

  localparam int WIDTH   = 16;
  localparam int NREG    = 8;
  localparam int RADDR_W = 3;

  typedef logic [RADDR_W-1:0] reg_num_t;
  typedef logic [WIDTH-1:0]   word_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + 4'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/register_bank_reg16_en.sv
// Load-enabled data register with asynchronous active-low clear; one per
// architectural register in the bank.
module reg16_en #(
  parameter int WIDTH = register_bank_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/register_bank.sv
// Eight-entry register bank with one write-back port and a busy scoreboard
// that flags operand hazards on registers awaiting multi-cycle results.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int WIDTH = register_bank_pkg::WIDTH,
  parameter int NREG  = register_bank_pkg::NREG
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [RADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               issue_en,
  input  logic [RADDR_W-1:0] issue_dest,
  output logic               issue_ready,
  input  logic               rd_a_en,
  input  logic [RADDR_W-1:0] rd_a_sel,
  input  logic               rd_b_en,
  input  logic [RADDR_W-1:0] rd_b_sel,
  output logic [WIDTH-1:0]   reg0,
  output logic [WIDTH-1:0]   reg1,
  output logic [WIDTH-1:0]   reg2,
  output logic [WIDTH-1:0]   reg3,
  output logic [WIDTH-1:0]   reg4,
  output logic [WIDTH-1:0]   reg5,
  output logic [WIDTH-1:0]   reg6,
  output logic [WIDTH-1:0]   reg7,
  output logic [NREG-1:0]    busy,
  output logic [3:0]         pending_cnt,
  output logic               stall
);

  logic [NREG-1:0]  busy_reg;
  logic [NREG-1:0]  busy_next;
  logic [NREG-1:0]  wr_dec;
  logic [WIDTH-1:0] q_arr [NREG];
  logic             issue_accept;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_regs
      assign wr_dec[gi] = wr_en && (wr_addr == RADDR_W'(gi));

      reg16_en #(.WIDTH(WIDTH)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_dec[gi]),
        .d     (wr_data),
        .q     (q_arr[gi])
      );
    end
  endgenerate

  assign issue_ready  = !busy_reg[issue_dest];
  assign issue_accept = issue_en && issue_ready;

  // No bypass: a register being written this cycle still stalls its reader.
  assign stall = (rd_a_en && busy_reg[rd_a_sel]) || (rd_b_en && busy_reg[rd_b_sel]);

  // Issue is applied after the write-back clear so a same-register race
  // leaves the register busy.
  always_comb begin
    busy_next = busy_reg;
    if (wr_en) begin
      busy_next[wr_addr] = 1'b0;
    end
    if (issue_accept) begin
      busy_next[issue_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy        = busy_reg;
  assign pending_cnt = popcount8(busy_reg);

  assign reg0 = q_arr[0];
  assign reg1 = q_arr[1];
  assign reg2 = q_arr[2];
  assign reg3 = q_arr[3];
  assign reg4 = q_arr[4];
  assign reg5 = q_arr[5];
  assign reg6 = q_arr[6];
  assign reg7 = q_arr[7];

endmodule
